// File: rtl/mac_host_pkg.sv
// Shared definitions for the MAC management register-bus master.
// Contents: register index constants, bus FSM and statistics-engine state
// enums, the poll counter width and a helper that forms the byte address.
package mac_host_pkg;

  localparam int REG_IDX_W = 7;
  localparam int POLL_W    = 8;

  // Register indices (the byte address on the bus is index*2)
  localparam logic [REG_IDX_W-1:0] IDX_TX_CONFIG   = 7'd0;
  localparam logic [REG_IDX_W-1:0] IDX_RX_CONFIG   = 7'd1;
  localparam logic [REG_IDX_W-1:0] IDX_CPU_RD_ADDR = 7'd28;
  localparam logic [REG_IDX_W-1:0] IDX_CPU_RD_APPL = 7'd29;
  localparam logic [REG_IDX_W-1:0] IDX_CPU_RD_GNT  = 7'd30;
  localparam logic [REG_IDX_W-1:0] IDX_CPU_RD_DL   = 7'd31;
  localparam logic [REG_IDX_W-1:0] IDX_CPU_RD_DH   = 7'd32;
  localparam logic [REG_IDX_W-1:0] IDX_LAST        = 7'd34;

  typedef enum logic [1:0] {
    BUS_IDLE    = 2'd0,
    BUS_ACCESS  = 2'd1,
    BUS_RELEASE = 2'd2
  } bus_state_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ADDR  = 3'd1,
    ST_APPLY = 3'd2,
    ST_POLL  = 3'd3,
    ST_LO    = 3'd4,
    ST_HI    = 3'd5,
    ST_CLR   = 3'd6
  } stat_step_e;

  function automatic logic [7:0] byte_addr(input logic [REG_IDX_W-1:0] idx);
    return {idx, 1'b0};
  endfunction

endpackage

// File: rtl/mac_host_bus_ctrl_rr_arbiter.sv
// Round-robin arbiter over N slots.
// Ports: req_i (per-slot request), ptr_i (highest-priority slot this cycle),
// lock_i (when set only slot N-1 may win), gnt_valid_o / gnt_idx_o (winner).
// Purely combinational; the pointer is owned by the instantiating block.
module rr_arbiter #(
  parameter int N  = 3,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  input  logic          lock_i,
  output logic          gnt_valid_o,
  output logic [PW-1:0] gnt_idx_o
);

  localparam logic [N-1:0] LOCK_MASK = {1'b1, {(N-1){1'b0}}};

  logic [N-1:0]  eligible_s;
  logic          found_s;
  logic [PW-1:0] sel_s;

  // Scan slots starting at the pointer and wrap; first eligible slot wins.
  always_comb begin
    int raw;
    int cand;
    logic hit;
    eligible_s = lock_i ? (req_i & LOCK_MASK) : req_i;
    found_s    = 1'b0;
    sel_s      = '0;
    raw        = 0;
    cand       = 0;
    hit        = 1'b0;
    for (int k = 0; k < N; k++) begin
      raw     = int'(ptr_i) + k;
      cand    = (raw >= N) ? (raw - N) : raw;
      hit     = !found_s && eligible_s[cand];
      sel_s   = hit ? PW'(cand) : sel_s;
      found_s = found_s | hit;
    end
  end

  assign gnt_valid_o = found_s;
  assign gnt_idx_o   = sel_s;

endmodule

// File: rtl/mac_host_bus_ctrl.sv
// MAC management register-bus master.
// Shares the csb/wrb/ca/cd bus between NUM_REQ requesters and an internal
// statistics read engine (arbiter slot NUM_REQ) and runs the 3-cycle
// IDLE -> ACCESS -> RELEASE register access for each granted transaction.
// Ports: req_* / rsp_* requester handshake, stat_* statistics engine
// control and result, csb/wrb/ca/cd_in/cd_out register bus.
module mac_host_bus_ctrl
  import mac_host_pkg::*;
#(
  parameter int NUM_REQ  = 2,
  parameter int POLL_MAX = 255
) (
  input  logic                    clk_reg,
  input  logic                    reset,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [NUM_REQ-1:0]      req_write,
  input  logic [NUM_REQ*7-1:0]    req_addr,
  input  logic [NUM_REQ*16-1:0]   req_wdata,
  output logic [NUM_REQ-1:0]      req_ready,
  output logic [NUM_REQ-1:0]      rsp_valid,
  output logic [15:0]             rsp_rdata,
  input  logic                    stat_req,
  input  logic [15:0]             stat_addr,
  output logic                    stat_busy,
  output logic                    stat_done,
  output logic                    stat_err,
  output logic [31:0]             stat_data,
  output logic                    csb,
  output logic                    wrb,
  output logic [7:0]              ca,
  output logic [15:0]             cd_in,
  input  logic [15:0]             cd_out
);

  localparam int NSLOT = NUM_REQ + 1;
  localparam int GW    = $clog2(NSLOT);
  localparam logic [GW-1:0]     STAT_SLOT  = GW'(NUM_REQ);
  localparam logic [POLL_W-1:0] POLL_LIMIT = POLL_W'(POLL_MAX);

  bus_state_e         state_q, state_d;
  stat_step_e         step_q, step_d;
  logic [GW-1:0]      ptr_q, ptr_d, grant_q, grant_d;
  logic               lock_q, lock_d, wr_q, wr_d;
  logic               csb_q, csb_d, wrb_q, wrb_d;
  logic [7:0]         ca_q, ca_d;
  logic [15:0]        cd_in_q, cd_in_d, cap_q, cap_d;
  logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
  logic [15:0]        rsp_rdata_q, rsp_rdata_d;
  logic [15:0]        stat_addr_q, stat_addr_d;
  logic [POLL_W-1:0]  poll_cnt_q, poll_cnt_d;
  logic               err_flag_q, err_flag_d;
  logic [15:0]        dout_l_q, dout_l_d, dout_h_q, dout_h_d;
  logic               stat_busy_q, stat_busy_d, stat_done_q, stat_done_d;
  logic               stat_err_q, stat_err_d;
  logic [31:0]        stat_data_q, stat_data_d;

  logic [NSLOT-1:0]   slot_req_s;
  logic               gnt_valid_s;
  logic [GW-1:0]      gnt_idx_s;
  logic [6:0]         txn_addr_s;
  logic               txn_write_s;
  logic [15:0]        txn_wdata_s;
  logic [POLL_W-1:0]  poll_inc_s;

  assign slot_req_s = {stat_busy_q && (step_q != ST_IDLE), req_valid};
  assign poll_inc_s = poll_cnt_q + 8'd1;

  rr_arbiter #(.N(NSLOT)) u_arb (
    .req_i       (slot_req_s),
    .ptr_i       (ptr_q),
    .lock_i      (lock_q),
    .gnt_valid_o (gnt_valid_s),
    .gnt_idx_o   (gnt_idx_s)
  );

  // Accept strobe: only in IDLE, for the granted requester, while unlocked.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      req_ready[i] = !reset && (state_q == BUS_IDLE) && gnt_valid_s &&
                     (gnt_idx_s == GW'(i)) && !lock_q;
    end
  end

  // Transaction fields of the granted slot; the stat slot derives them from its step.
  always_comb begin
    txn_addr_s  = 7'd0;
    txn_write_s = 1'b0;
    txn_wdata_s = 16'd0;
    if (gnt_idx_s == STAT_SLOT) begin
      case (step_q)
        ST_ADDR:  begin txn_addr_s = IDX_CPU_RD_ADDR; txn_write_s = 1'b1; txn_wdata_s = stat_addr_q; end
        ST_APPLY: begin txn_addr_s = IDX_CPU_RD_APPL; txn_write_s = 1'b1; txn_wdata_s = 16'd1; end
        ST_POLL:  begin txn_addr_s = IDX_CPU_RD_GNT;  txn_write_s = 1'b0; txn_wdata_s = 16'd0; end
        ST_LO:    begin txn_addr_s = IDX_CPU_RD_DL;   txn_write_s = 1'b0; txn_wdata_s = 16'd0; end
        ST_HI:    begin txn_addr_s = IDX_CPU_RD_DH;   txn_write_s = 1'b0; txn_wdata_s = 16'd0; end
        ST_CLR:   begin txn_addr_s = IDX_CPU_RD_APPL; txn_write_s = 1'b1; txn_wdata_s = 16'd0; end
        default:  begin txn_addr_s = 7'd0;            txn_write_s = 1'b0; txn_wdata_s = 16'd0; end
      endcase
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        txn_addr_s  = (gnt_idx_s == GW'(i)) ? req_addr[7*i +: 7]   : txn_addr_s;
        txn_write_s = (gnt_idx_s == GW'(i)) ? req_write[i]         : txn_write_s;
        txn_wdata_s = (gnt_idx_s == GW'(i)) ? req_wdata[16*i +: 16] : txn_wdata_s;
      end
    end
  end

  // Next-state logic for the bus FSM and the statistics engine.
  always_comb begin
    state_d     = state_q;
    step_d      = step_q;
    ptr_d       = ptr_q;
    grant_d     = grant_q;
    lock_d      = lock_q;
    wr_d        = wr_q;
    csb_d       = csb_q;
    wrb_d       = wrb_q;
    ca_d        = ca_q;
    cd_in_d     = cd_in_q;
    cap_d       = cap_q;
    rsp_valid_d = '0;
    rsp_rdata_d = rsp_rdata_q;
    stat_addr_d = stat_addr_q;
    poll_cnt_d  = poll_cnt_q;
    err_flag_d  = err_flag_q;
    dout_l_d    = dout_l_q;
    dout_h_d    = dout_h_q;
    stat_busy_d = stat_busy_q;
    stat_done_d = 1'b0;
    stat_err_d  = 1'b0;
    stat_data_d = stat_data_q;

    // New statistics request is only looked at while the engine is free.
    if (!stat_busy_q && stat_req) begin
      stat_busy_d = 1'b1;
      stat_addr_d = stat_addr;
      step_d      = ST_ADDR;
      poll_cnt_d  = 8'd0;
      err_flag_d  = 1'b0;
    end else begin
      stat_busy_d = stat_busy_d;
    end

    case (state_q)
      BUS_IDLE: begin
        if (gnt_valid_s) begin
          ca_d    = byte_addr(txn_addr_s);
          cd_in_d = txn_write_s ? txn_wdata_s : 16'd0;
          csb_d   = 1'b0;
          wrb_d   = ~txn_write_s;
          wr_d    = txn_write_s;
          grant_d = gnt_idx_s;
          ptr_d   = (gnt_idx_s == STAT_SLOT) ? '0 : (gnt_idx_s + GW'(1));
          lock_d  = lock_q | (gnt_idx_s == STAT_SLOT);
          state_d = BUS_ACCESS;
        end else begin
          state_d = BUS_IDLE;
        end
      end
      BUS_ACCESS: begin
        cap_d   = wr_q ? 16'd0 : cd_out;
        csb_d   = 1'b1;
        wrb_d   = 1'b1;
        cd_in_d = 16'd0;
        for (int i = 0; i < NUM_REQ; i++) begin
          rsp_valid_d[i] = (grant_q == GW'(i));
        end
        rsp_rdata_d = (grant_q == STAT_SLOT || wr_q) ? 16'd0 : cd_out;
        state_d     = BUS_RELEASE;
      end
      BUS_RELEASE: begin
        rsp_rdata_d = 16'd0;
        state_d     = BUS_IDLE;
        if (grant_q == STAT_SLOT) begin
          case (step_q)
            ST_ADDR:  step_d = ST_APPLY;
            ST_APPLY: begin step_d = ST_POLL; poll_cnt_d = 8'd0; end
            ST_POLL: begin
              if (cap_q[0]) begin
                step_d = ST_LO;
              end else begin
                poll_cnt_d = poll_inc_s;
                // Give up after POLL_MAX unsuccessful polls, still releasing the apply bit.
                if (poll_inc_s >= POLL_LIMIT) begin
                  step_d     = ST_CLR;
                  err_flag_d = 1'b1;
                end else begin
                  step_d = ST_POLL;
                end
              end
            end
            ST_LO:    begin dout_l_d = cap_q; step_d = ST_HI; end
            ST_HI:    begin dout_h_d = cap_q; step_d = ST_CLR; end
            ST_CLR: begin
              step_d      = ST_IDLE;
              stat_busy_d = 1'b0;
              lock_d      = 1'b0;
              stat_done_d = 1'b1;
              stat_err_d  = err_flag_q;
              stat_data_d = err_flag_q ? stat_data_q : {dout_h_q, dout_l_q};
            end
            default: begin
              step_d      = ST_IDLE;
              stat_busy_d = 1'b0;
              lock_d      = 1'b0;
            end
          endcase
        end else begin
          step_d = step_d;
        end
      end
      default: begin
        state_d = BUS_IDLE;
        csb_d   = 1'b1;
        wrb_d   = 1'b1;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk_reg) begin
    if (reset) begin
      state_q     <= BUS_IDLE;
      step_q      <= ST_IDLE;
      ptr_q       <= '0;
      grant_q     <= '0;
      lock_q      <= 1'b0;
      wr_q        <= 1'b0;
      csb_q       <= 1'b1;
      wrb_q       <= 1'b1;
      ca_q        <= 8'd0;
      cd_in_q     <= 16'd0;
      cap_q       <= 16'd0;
      rsp_valid_q <= '0;
      rsp_rdata_q <= 16'd0;
      stat_addr_q <= 16'd0;
      poll_cnt_q  <= 8'd0;
      err_flag_q  <= 1'b0;
      dout_l_q    <= 16'd0;
      dout_h_q    <= 16'd0;
      stat_busy_q <= 1'b0;
      stat_done_q <= 1'b0;
      stat_err_q  <= 1'b0;
      stat_data_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      step_q      <= step_d;
      ptr_q       <= ptr_d;
      grant_q     <= grant_d;
      lock_q      <= lock_d;
      wr_q        <= wr_d;
      csb_q       <= csb_d;
      wrb_q       <= wrb_d;
      ca_q        <= ca_d;
      cd_in_q     <= cd_in_d;
      cap_q       <= cap_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      stat_addr_q <= stat_addr_d;
      poll_cnt_q  <= poll_cnt_d;
      err_flag_q  <= err_flag_d;
      dout_l_q    <= dout_l_d;
      dout_h_q    <= dout_h_d;
      stat_busy_q <= stat_busy_d;
      stat_done_q <= stat_done_d;
      stat_err_q  <= stat_err_d;
      stat_data_q <= stat_data_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign stat_busy = stat_busy_q;
  assign stat_done = stat_done_q;
  assign stat_err  = stat_err_q;
  assign stat_data = stat_data_q;
  assign csb       = csb_q;
  assign wrb       = wrb_q;
  assign ca        = ca_q;
  assign cd_in     = cd_in_q;

endmodule

// File: tb/tb_mac_host_bus_ctrl.sv
// Bench for mac_host_bus_ctrl: table vectors, randomized requester traffic
// against a round-robin/memory reference, statistics engine sequences and
// reset in the middle of a bus access. Contains a MAC register model.
module tb_mac_host_bus_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  req_valid, req_write, req_ready, rsp_valid;
  logic [13:0] req_addr;
  logic [31:0] req_wdata;
  logic [15:0] rsp_rdata, stat_addr, cd_in, cd_out;
  logic        stat_req, stat_busy, stat_done, stat_err, csb, wrb;
  logic [31:0] stat_data;
  logic [7:0]  ca;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic       w;
    logic [6:0] idx;
    logic [15:0] data;
  } bus_op_t;

  typedef struct {
    int          r;
    logic        w;
    logic [6:0]  idx;
    logic [15:0] wd;
    logic [7:0]  eca;
    logic [15:0] ecd;
    logic        ewrb;
    logic [15:0] erd;
  } vec_t;

  bus_op_t ops[$];
  bus_op_t exp_ops[$];
  logic [15:0] mac_regs [0:127];
  logic [15:0] ref_mem  [0:127];
  int polls_seen = 0;
  int grant_at   = 0;
  int model_ptr  = 0;

  mac_host_bus_ctrl #(.NUM_REQ(2), .POLL_MAX(4)) dut (
    .clk_reg(clk), .reset(reset), .req_valid(req_valid), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .stat_req(stat_req),
    .stat_addr(stat_addr), .stat_busy(stat_busy), .stat_done(stat_done),
    .stat_err(stat_err), .stat_data(stat_data), .csb(csb), .wrb(wrb),
    .ca(ca), .cd_in(cd_in), .cd_out(cd_out)
  );

  always #5 clk = ~clk;

  // MAC model: index 30 reports grant once enough polls have been made.
  always_comb begin
    if (ca[7:1] == 7'd30) cd_out = (grant_at != 0 && polls_seen + 1 >= grant_at) ? 16'd1 : 16'd0;
    else cd_out = mac_regs[ca[7:1]];
  end

  always @(posedge clk) begin
    if (!reset && csb == 1'b0) begin
      ops.push_back('{~wrb, ca[7:1], wrb ? cd_out : cd_in});
      if (!wrb) begin
        mac_regs[ca[7:1]] <= cd_in;
        if (ca[7:1] == 7'd29) polls_seen <= 0;
      end else if (ca[7:1] == 7'd30) begin
        polls_seen <= polls_seen + 1;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic int rr_predict(input int ptr, input logic [2:0] mask);
    for (int k = 0; k < 3; k++) begin
      int j;
      j = (ptr + k) % 3;
      if (mask[j]) return j;
    end
    return -1;
  endfunction

  // One transaction starting at a negedge in IDLE; returns at negedge of T+3.
  task automatic do_txn(input logic [1:0] vm, input logic [1:0] wr,
                        input logic [6:0] a0, input logic [6:0] a1,
                        input logic [15:0] d0, input logic [15:0] d1, input int g,
                        input logic [7:0] eca, input logic [15:0] ecd,
                        input logic ewrb, input logic [15:0] erd);
    req_valid = vm; req_write = wr; req_addr = {a1, a0}; req_wdata = {d1, d0};
    #1;
    chk("ready", 32'(req_ready), 32'(2'b01 << g));
    @(negedge clk);
    chk("ready_busy", 32'(req_ready), 32'd0);
    chk("csb_low", 32'(csb), 32'd0);
    chk("wrb", 32'(wrb), 32'(ewrb));
    chk("ca", 32'(ca), 32'(eca));
    chk("cd_in", 32'(cd_in), 32'(ecd));
    req_valid = 2'b00;
    @(negedge clk);
    chk("rsp_valid", 32'(rsp_valid), 32'(2'b01 << g));
    chk("rsp_rdata", 32'(rsp_rdata), 32'(erd));
    chk("csb_high", 32'(csb), 32'd1);
    @(negedge clk);
    chk("rsp_drop", 32'(rsp_valid), 32'd0);
    model_ptr = (g + 1) % 3;
  endtask

  task automatic build_stat_exp(input logic [15:0] addr, input int npoll, input bit ok,
                                input logic [15:0] lo, input logic [15:0] hi);
    exp_ops.delete();
    exp_ops.push_back('{1'b1, 7'd28, addr});
    exp_ops.push_back('{1'b1, 7'd29, 16'd1});
    for (int p = 1; p <= npoll; p++) exp_ops.push_back('{1'b0, 7'd30, (ok && p == npoll) ? 16'd1 : 16'd0});
    if (ok) begin
      exp_ops.push_back('{1'b0, 7'd31, lo});
      exp_ops.push_back('{1'b0, 7'd32, hi});
    end
    exp_ops.push_back('{1'b1, 7'd29, 16'd0});
  endtask

  task automatic cmp_ops(input string nm, input bus_op_t got[$]);
    chk({nm, "_nops"}, 32'(got.size()), 32'(exp_ops.size()));
    for (int i = 0; i < got.size() && i < exp_ops.size(); i++)
      chk({nm, "_op"}, 32'({got[i].w, got[i].idx, got[i].data}),
          32'({exp_ops[i].w, exp_ops[i].idx, exp_ops[i].data}));
  endtask

  // Runs a statistics read; returns at the negedge where stat_done is seen.
  task automatic run_stat(input logic [15:0] addr, input bit with_ext, output bus_op_t snap[$],
                          output bit seen_done);
    int stall_bad, data_bad;
    logic [31:0] held;
    stall_bad = 0; data_bad = 0; seen_done = 1'b0; held = stat_data;
    ops.delete();
    stat_req = 1'b1; stat_addr = addr;
    @(negedge clk);
    stat_req = 1'b0;
    chk("stat_busy", 32'(stat_busy), 32'd1);
    @(negedge clk);
    model_ptr = 0;
    if (with_ext) begin
      req_valid = 2'b11; req_write = 2'b00; req_addr = {7'd1, 7'd0};
    end
    for (int c = 0; c < 300; c++) begin
      @(negedge clk); #1;
      if (stat_done) begin
        seen_done = 1'b1;
        break;
      end
      if (req_ready != 2'b00) stall_bad++;
      if (stat_data != held) data_bad++;
    end
    chk("stat_done_seen", 32'(seen_done), 32'd1);
    chk("ext_stalled", 32'(stall_bad), 32'd0);
    chk("stat_data_held", 32'(data_bad), 32'd0);
    snap = ops;
  endtask

  initial begin
    vec_t vecs[7];
    bus_op_t snap[$];
    bit done_ok;
    int nrr, last_cyc, g;

    for (int i = 0; i < 128; i++) mac_regs[i] = 16'(i * 3 + 1);
    mac_regs[22] = 16'h01AE; mac_regs[127] = 16'h7A7A;
    mac_regs[31] = 16'h1234; mac_regs[32] = 16'hABCD;

    vecs[0] = '{0, 1'b1, 7'd4,   16'h000C, 8'h08, 16'h000C, 1'b0, 16'h0000};
    vecs[1] = '{1, 1'b0, 7'd22,  16'h0000, 8'h2C, 16'h0000, 1'b1, 16'h01AE};
    vecs[2] = '{0, 1'b0, 7'd4,   16'h0000, 8'h08, 16'h0000, 1'b1, 16'h000C};
    vecs[3] = '{1, 1'b1, 7'd34,  16'hBEEF, 8'h44, 16'hBEEF, 1'b0, 16'h0000};
    vecs[4] = '{0, 1'b1, 7'd100, 16'h5555, 8'hC8, 16'h5555, 1'b0, 16'h0000};
    vecs[5] = '{1, 1'b0, 7'd100, 16'h0000, 8'hC8, 16'h0000, 1'b1, 16'h5555};
    vecs[6] = '{0, 1'b0, 7'd127, 16'h0000, 8'hFE, 16'h0000, 1'b1, 16'h7A7A};

    reset = 1'b1; req_valid = 2'b01; req_write = 2'b00; req_addr = 14'd0;
    req_wdata = 32'd0; stat_req = 1'b0; stat_addr = 16'd0;
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_csb", 32'(csb), 32'd1);
    chk("rst_wrb", 32'(wrb), 32'd1);
    chk("rst_ca", 32'(ca), 32'd0);
    chk("rst_cd_in", 32'(cd_in), 32'd0);
    chk("rst_rsp", 32'({rsp_valid, rsp_rdata}), 32'd0);
    chk("rst_stat", 32'({stat_busy, stat_done, stat_err}), 32'd0);
    chk("rst_stat_data", stat_data, 32'd0);
    req_valid = 2'b00; reset = 1'b0;
    model_ptr = 0;

    for (int i = 0; i < 7; i++) begin
      logic [1:0] m, w;
      m = 2'b01 << vecs[i].r;
      w = vecs[i].w ? m : 2'b00;
      do_txn(m, w, (vecs[i].r == 0) ? vecs[i].idx : 7'd0, (vecs[i].r == 1) ? vecs[i].idx : 7'd0,
             (vecs[i].r == 0) ? vecs[i].wd : 16'd0, (vecs[i].r == 1) ? vecs[i].wd : 16'd0,
             vecs[i].r, vecs[i].eca, vecs[i].ecd, vecs[i].ewrb, vecs[i].erd);
    end

    // Both requesters held valid: grants must alternate with 3-cycle spacing.
    req_valid = 2'b11; req_write = 2'b11; req_addr = {7'd11, 7'd10}; req_wdata = {16'h2222, 16'h1111};
    nrr = 0; last_cyc = -1;
    for (int c = 0; c < 40 && nrr < 6; c++) begin
      #1;
      if (req_ready != 2'b00) begin
        g = rr_predict(model_ptr, 3'b011);
        chk("rr_grant", 32'(req_ready), 32'(2'b01 << g));
        if (last_cyc >= 0) chk("rr_spacing", 32'(c - last_cyc), 32'd3);
        last_cyc = c; model_ptr = (g + 1) % 3; nrr++;
      end
      @(negedge clk);
    end
    chk("rr_count", 32'(nrr), 32'd6);
    req_valid = 2'b00;
    repeat (3) @(negedge clk);
    mac_regs[10] = 16'h1111; mac_regs[11] = 16'h2222;

    // Random traffic against round-robin and memory reference.
    for (int i = 0; i < 128; i++) ref_mem[i] = mac_regs[i];
    for (int it = 0; it < 24; it++) begin
      logic [1:0] vm, wr;
      logic [6:0] a0, a1, ag;
      logic [15:0] d0, d1, dg, erd;
      vm = 2'($urandom_range(1, 3)); wr = 2'($urandom_range(0, 3));
      a0 = 7'($urandom_range(0, 27)); a1 = 7'($urandom_range(0, 27));
      d0 = 16'($urandom); d1 = 16'($urandom);
      g = rr_predict(model_ptr, {1'b0, vm});
      ag = (g == 0) ? a0 : a1;
      dg = (g == 0) ? d0 : d1;
      erd = wr[g] ? 16'd0 : ref_mem[ag];
      if (wr[g]) ref_mem[ag] = dg;
      do_txn(vm, wr, a0, a1, d0, d1, g, {ag, 1'b0}, wr[g] ? dg : 16'd0, ~wr[g], erd);
    end

    // Statistics read granted on the third poll, externals stalled meanwhile.
    grant_at = 3;
    run_stat(16'h0005, 1'b1, snap, done_ok);
    chk("stat_err_ok", 32'(stat_err), 32'd0);
    chk("stat_data", stat_data, 32'hABCD1234);
    chk("stat_busy_clr", 32'(stat_busy), 32'd0);
    chk("ext_after_stat", 32'(req_ready), 32'(2'b01 << rr_predict(model_ptr, 3'b011)));
    model_ptr = 1;
    build_stat_exp(16'h0005, 3, 1'b1, 16'h1234, 16'hABCD);
    cmp_ops("stat_ok", snap);
    @(negedge clk);
    req_valid = 2'b00;
    repeat (3) @(negedge clk);

    // Grant never comes: POLL_MAX polls, then release with error.
    grant_at = 0;
    run_stat(16'h0033, 1'b0, snap, done_ok);
    chk("stat_err_to", 32'(stat_err), 32'd1);
    chk("stat_data_to", stat_data, 32'hABCD1234);
    build_stat_exp(16'h0033, 4, 1'b0, 16'd0, 16'd0);
    cmp_ops("stat_to", snap);
    @(negedge clk);
    chk("stat_done_pulse", 32'({stat_done, stat_err}), 32'd0);
    repeat (2) @(negedge clk);

    // Reset during the csb=0 cycle drops the transaction.
    req_valid = 2'b01; req_write = 2'b01; req_addr = {7'd0, 7'd5}; req_wdata = {16'd0, 16'h0F0F};
    @(negedge clk);
    chk("mid_csb_low", 32'(csb), 32'd0);
    reset = 1'b1; req_valid = 2'b00;
    @(negedge clk);
    chk("mid_rst_bus", 32'({csb, wrb, ca, cd_in}), 32'({1'b1, 1'b1, 8'd0, 16'd0}));
    chk("mid_rst_stat_data", stat_data, 32'd0);
    reset = 1'b0;
    begin
      int rsp_seen;
      rsp_seen = 0;
      for (int c = 0; c < 6; c++) begin
        @(negedge clk);
        if (rsp_valid != 2'b00) rsp_seen++;
      end
      chk("mid_rst_no_rsp", 32'(rsp_seen), 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mac_host_bus_ctrl.md
Name: mac_host_bus_ctrl

Overview:
Synthesizable master for the MAC management register bus (csb/wrb/ca/cd_in/cd_out). Shares the bus between NUM_REQ external requesters with a round-robin arbiter, and runs the 2-phase register access protocol for each transaction. Contains a built-in statistics read engine that performs the indirect CPU_rd handshake: write addr, apply, poll grant, read dout_l/dout_h, release. It sits between the management/config logic and the MAC register block.

Parameters:
NUM_REQ, 2, number of external requesters (1..4)
POLL_MAX, 255, maximum CPU_rd_grant polls before timeout (8-bit)

Ports:
clk_reg  in  1  register-bus clock
reset  in  1  synchronous, active-high reset
req_valid  in  NUM_REQ  per-requester request
req_write  in  NUM_REQ  1=write, 0=read
req_addr  in  NUM_REQ*7  register index, slice i = [7i+6:7i]
req_wdata  in  NUM_REQ*16  write data, slice i = [16i+15:16i]
req_ready  out  NUM_REQ  accept strobe; request taken when valid&ready
rsp_valid  out  NUM_REQ  1-cycle response pulse to the granted requester
rsp_rdata  out  16  read data, valid with rsp_valid (0 for writes)
stat_req  in  1  start indirect statistics read
stat_addr  in  16  statistics counter address
stat_busy  out  1  engine active
stat_done  out  1  1-cycle completion pulse
stat_err  out  1  with stat_done: grant timeout
stat_data  out  32  {dout_h, dout_l}, held until next stat_done
csb  out  1  chip select, active low
wrb  out  1  write strobe, active low
ca  out  8  byte address = {index, 1'b0}
cd_in  out  16  write data to the MAC
cd_out  in  16  read data from the MAC

Behaviour:
- Reset, synchronous and active-high, applies on any cycle and in any state. It forces csb=1, wrb=1, ca=0, cd_in=0, and all of req_ready, rsp_valid, rsp_rdata, stat_busy, stat_done, stat_err and stat_data to 0. It clears the arbiter pointer to 0 and the lock, and drops any in-flight transaction silently.
- Bus FSM states are IDLE, ACCESS and RELEASE. All bus outputs are registered.
- IDLE:
  - A slot is chosen by round-robin over slots 0..NUM_REQ, where slot NUM_REQ is the stat engine.
  - req_ready[i]=1 combinationally only when state=IDLE, slot i is granted and the lock is clear.
  - On accept: register ca={addr,0}, cd_in=wdata (0 for reads), csb=0 and wrb=~write, then go to ACCESS.
  - The pointer moves to grant+1 (mod NUM_REQ+1).
- ACCESS: csb=0 for exactly one cycle. On the closing edge: cd_out is captured, csb=1, wrb=1, cd_in=0, and the FSM goes to RELEASE. ca holds its value.
- RELEASE: rsp_valid[grant]=1 and rsp_rdata=captured data (0 for writes). The FSM then returns to IDLE.
- One transaction takes 3 cycles. Accept-to-rsp_valid latency is 2 cycles.
- Address indices above 34 are issued unchanged. No decode is done here.
- Stat engine:
  - stat_req is sampled only when stat_busy=0. stat_addr is latched and stat_busy is set.
  - Each step is one bus transaction through arbiter slot NUM_REQ.
  - The lock is set once the first step is granted. It blocks external grants until the sequence ends, so index 28/29 writes cannot interleave.
  - Steps:
    - S_ADDR: write idx28 = stat_addr.
    - S_APPLY: write idx29 = 1.
    - S_POLL: read idx30. If bit0=1, go to S_LO. Otherwise increment the poll count; at POLL_MAX go to S_CLR with the error flag set.
    - S_LO: read idx31.
    - S_HI: read idx32.
    - S_CLR: write idx29 = 0.
  - After S_CLR: pulse stat_done (with stat_err if the flag is set), clear stat_busy and the lock.
  - On timeout, stat_data is left unchanged.
- Simultaneous events:
  - An external request and stat_req in the same cycle are resolved by the round-robin.
  - stat_req while busy is ignored.
  - A requester dropping req_valid before acceptance is legal.

Decomposition:
- Package mac_host_pkg holds:
  - register index constants 0..34, at least TX/RX config, CPU_rd_addr=28, CPU_rd_apply=29, CPU_rd_grant=30, CPU_rd_dout_l=31, CPU_rd_dout_h=32
  - bus FSM enum
  - stat engine enum
  - POLL width
- Sub-module rr_arbiter holds the parameterized round-robin grant with pointer and lock input, instantiated with NUM_REQ+1 slots.

Test Plan:
- Reset mid-ACCESS: assert reset during a csb=0 cycle -> next cycle csb=1, wrb=1, ca=0, and no rsp_valid ever follows for that transaction.
- Requester 0 writes idx4=0x000C -> req_ready at T, ca=0x08, cd_in=0x000C, csb=0 and wrb=0 at T+1, rsp_valid[0] at T+2 with rdata=0.
- Requester 1 reads idx22 with the model returning 0x01AE -> ca=0x2C, wrb=1, rsp_rdata=0x01AE at T+2.
- Both requesters hold valid for 6 transactions -> grants alternate 0,1,0,1,0,1 with no bus cycle lost beyond 3-cycle spacing.
- stat_req with stat_addr=0x0005 and the model granting on the third poll, dout_l=0x1234, dout_h=0xABCD -> bus ops 28w,29w,30r×3,31r,32r,29w(0), stat_data=0xABCD1234, stat_err=0. External requests stay stalled throughout.
- Grant never asserted with POLL_MAX=4 -> exactly 4 polls, then 29w(0), stat_done=1, stat_err=1, stat_data unchanged.
